// File: rtl/vram_fifo_port.sv
// VRAM FIFO port: buffered write and prefetched read access to a single-port
// memory backend. Ports: clk/reset; client write_ld/writeaddr/write_req/
// writedata/wr_full; client read_ld/readaddr/read_req/readdata/rd_empty;
// backend mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata.
// Optional VRAM_PORT_ERR_EN adds sticky wr_overflow/rd_underflow outputs.
module vram_fifo_port #(
  parameter int WR_DEPTH = 8,
  parameter int RD_DEPTH = 8,
  parameter int AW       = 25,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_ld,
  input  logic [AW-1:0] writeaddr,
  input  logic          write_req,
  input  logic [DW-1:0] writedata,
  output logic          wr_full,
  input  logic          read_ld,
  input  logic [AW-1:0] readaddr,
  input  logic          read_req,
  output logic [DW-1:0] readdata,
  output logic          rd_empty,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
`ifdef VRAM_PORT_ERR_EN
  ,
  output logic          wr_overflow,
  output logic          rd_underflow
`endif
);

  localparam int WPW = $clog2(WR_DEPTH);
  localparam int RPW = $clog2(RD_DEPTH);
  localparam logic [WPW:0] WFULL = (WPW+1)'(WR_DEPTH);
  localparam logic [RPW:0] RFULL = (RPW+1)'(RD_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WR_BUSY,
    RD_BUSY
  } state_t;

  state_t state, state_n;

  logic [AW-1:0]  wptr, rptr;
  logic [AW-1:0]  wq_addr [WR_DEPTH];
  logic [DW-1:0]  wq_data [WR_DEPTH];
  logic [DW-1:0]  rq_data [RD_DEPTH];
  logic [WPW-1:0] wq_rp, wq_wp, wp_base;
  logic [WPW:0]   wq_cnt, wcnt_base;
  logic [RPW-1:0] rq_rp, rq_wp;
  logic [RPW:0]   rq_cnt;
  logic [AW-1:0]  waddr_base;
  logic           rd_active, wr_stale, rd_stale, rd_turn;
  logic           ack_wr, ack_rd, push, w_deq, pop, r_enq;
  logic           wr_pend, rd_elig, take_wr, take_rd;
  logic           issue_wr, issue_rd;

  assign wr_full  = (wq_cnt == WFULL);
  assign rd_empty = (rq_cnt == '0);
  assign readdata = rd_empty ? '0 : rq_data[rq_rp];
  assign mem_req  = (state != IDLE);
  assign mem_we   = (state == WR_BUSY);

  assign ack_wr = (state == WR_BUSY) && mem_ack;
  assign ack_rd = (state == RD_BUSY) && mem_ack;

  // A load flushes first, so a same-cycle push lands in the empty FIFO.
  assign push  = write_req && (write_ld || !wr_full);
  // Acks of accesses that a load has since invalidated change nothing.
  assign w_deq = ack_wr && !wr_stale && !write_ld;
  assign pop   = read_req && !rd_empty && !read_ld;
  assign r_enq = ack_rd && !rd_stale && !read_ld;

  assign wp_base    = write_ld ? wq_rp : wq_wp;
  assign wcnt_base  = write_ld ? '0 : wq_cnt;
  assign waddr_base = write_ld ? writeaddr : wptr;

  // Never start an access for state a load is replacing this cycle.
  assign wr_pend = (wq_cnt != '0) && !write_ld;
  assign rd_elig = rd_active && !read_ld && (rq_cnt < RFULL);
  assign take_wr = wr_pend && (!rd_elig || !rd_turn);
  assign take_rd = rd_elig && !take_wr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          take_wr: begin
            state_n  = WR_BUSY;
            issue_wr = 1'b1;
          end
          take_rd: begin
            state_n  = RD_BUSY;
            issue_rd = 1'b1;
          end
          default: ;
        endcase
      end
      WR_BUSY, RD_BUSY: begin
        if (mem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wq_addr[wp_base] <= waddr_base;
      wq_data[wp_base] <= writedata;
    end
    if (r_enq) rq_data[rq_wp] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      wq_rp    <= '0;
      wq_wp    <= '0;
      wq_cnt   <= '0;
      wr_stale <= 1'b0;
    end else begin
      wptr   <= waddr_base + AW'(push);
      wq_wp  <= wp_base + WPW'(push);
      wq_cnt <= wcnt_base + (WPW+1)'(push)
              - (WPW+1)'(w_deq);
      if (w_deq) wq_rp <= wq_rp + 1'b1;
      if (ack_wr)
        wr_stale <= 1'b0;
      else if (write_ld && state == WR_BUSY)
        wr_stale <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr      <= '0;
      rq_rp     <= '0;
      rq_wp     <= '0;
      rq_cnt    <= '0;
      rd_active <= 1'b0;
      rd_stale  <= 1'b0;
    end else begin
      if (read_ld) begin
        rptr      <= readaddr;
        rq_cnt    <= '0;
        rq_wp     <= rq_rp;
        rd_active <= 1'b1;
      end else begin
        if (issue_rd) rptr <= rptr + 1'b1;
        rq_cnt <= rq_cnt + (RPW+1)'(r_enq)
                - (RPW+1)'(pop);
        if (r_enq) rq_wp <= rq_wp + 1'b1;
        if (pop)   rq_rp <= rq_rp + 1'b1;
      end
      if (ack_rd)
        rd_stale <= 1'b0;
      else if (read_ld && state == RD_BUSY)
        rd_stale <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_turn   <= 1'b0;
    end else if (issue_wr) begin
      mem_addr  <= wq_addr[wq_rp];
      mem_wdata <= wq_data[wq_rp];
      rd_turn   <= 1'b1;
    end else if (issue_rd) begin
      mem_addr  <= rptr;
      rd_turn   <= 1'b0;
    end
  end

`ifdef VRAM_PORT_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (write_req && wr_full && !write_ld)
        wr_overflow <= 1'b1;
      if (read_req && rd_empty)
        rd_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_fifo_port.sv
// Self-checking bench for vram_fifo_port: directed sequences, a cycle
// table for read prefetch timing, and a randomized queue-model phase.
module tb_vram_fifo_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_ld, write_req, read_ld, read_req;
  logic [24:0] writeaddr, readaddr;
  logic [15:0] writedata, readdata;
  logic        wr_full, rd_empty;
  logic        mem_req, mem_we, mem_ack;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef VRAM_PORT_ERR_EN
  logic        wr_overflow, rd_underflow;
`endif

  logic        ack_en;
  logic [15:0] bmem [256];

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
  } acc_t;
  acc_t log_q[$];

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic        rld;
    logic [24:0] raddr;
    logic        rreq;
    logic        e_empty;
    logic [15:0] e_data;
    logic        e_req;
    logic [24:0] e_addr;
  } vec_t;
  vec_t tv[9];

  int checks = 0;
  int errors = 0;

  assign mem_ack   = ack_en & mem_req;
  assign mem_rdata = bmem[mem_addr[7:0]];

  always #5 clk = ~clk;

  vram_fifo_port dut (
    .clk(clk), .reset(reset),
    .write_ld(write_ld), .writeaddr(writeaddr),
    .write_req(write_req), .writedata(writedata),
    .wr_full(wr_full),
    .read_ld(read_ld), .readaddr(readaddr),
    .read_req(read_req), .readdata(readdata),
    .rd_empty(rd_empty),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef VRAM_PORT_ERR_EN
    ,
    .wr_overflow(wr_overflow),
    .rd_underflow(rd_underflow)
`endif
  );

  function automatic logic [15:0] pat(int a);
    return 16'((a & 255) * 257) ^ 16'h5A5A;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) bmem[i] = pat(i);
  endtask

  task automatic cyc();
    logic        held, hw;
    logic [24:0] ha;
    logic [15:0] hd;
    held = mem_req && !ack_en && !reset;
    hw = mem_we;
    ha = mem_addr;
    hd = mem_wdata;
    if (mem_req && ack_en && !reset) begin
      log_q.push_back('{mem_we, mem_addr, mem_wdata});
      if (mem_we) bmem[mem_addr[7:0]] = mem_wdata;
    end
    @(posedge clk);
    #1;
    if (held && !reset) begin
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_we", 32'(mem_we), 32'(hw));
      chk("hold_addr", 32'(mem_addr), 32'(ha));
      chk("hold_wdata", 32'(mem_wdata), 32'(hd));
    end
  endtask

  task automatic idle_in();
    write_ld = 0; write_req = 0; read_ld = 0;
    read_req = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_in();
    cyc();
    cyc();
    reset = 0;
  endtask

  initial begin
    int n, mw, mr, npush, npop, nread;
    logic [15:0] wd;
    reset = 1; ack_en = 0;
    writeaddr = 0; readaddr = 0; writedata = 0;
    idle_in();
    fill_mem();
    do_reset();

    chk("rst_wr_full", 32'(wr_full), 0);
    chk("rst_rd_empty", 32'(rd_empty), 1);
    chk("rst_readdata", 32'(readdata), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
`ifdef VRAM_PORT_ERR_EN
    chk("rst_ovf", 32'(wr_overflow), 0);
    chk("rst_unf", 32'(rd_underflow), 0);
`endif

    // Ordered writes with ack tied high.
    ack_en = 1;
    log_q.delete();
    write_ld = 1; writeaddr = 25'h10;
    cyc();
    write_ld = 0;
    for (int i = 0; i < 3; i++) begin
      write_req = 1; writedata = 16'hA0 + 16'(i);
      cyc();
      if (i == 1) begin
        chk("w_lat_req", 32'(mem_req), 1);
        chk("w_lat_we", 32'(mem_we), 1);
        chk("w_lat_addr", 32'(mem_addr), 32'h10);
      end
    end
    write_req = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("w_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      chk("w_we", 32'(log_q[i].we), 1);
      chk("w_addr", 32'(log_q[i].addr), 32'h10 + i);
      chk("w_data", 32'(log_q[i].data), 32'hA0 + i);
    end

    // Overflow: ack held low, one push too many.
    ack_en = 0;
    log_q.delete();
    write_ld = 1; writeaddr = 25'h100;
    cyc();
    write_ld = 0;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_not_full", 32'(wr_full), 0);
      write_req = 1; writedata = 16'hD0 + 16'(i);
      cyc();
    end
    chk("ovf_full", 32'(wr_full), 1);
    writedata = 16'hDEAD;
    cyc();
    write_req = 0;
    chk("ovf_still_full", 32'(wr_full), 1);
`ifdef VRAM_PORT_ERR_EN
    chk("ovf_flag", 32'(wr_overflow), 1);
`endif
    ack_en = 1;
    for (int i = 0; i < 30; i++) cyc();
    chk("ovf_drain_n", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("ovf_addr", 32'(log_q[i].addr), 32'h100 + i);
      chk("ovf_data", 32'(log_q[i].data), 32'hD0 + i);
    end
    chk("ovf_empty_after", 32'(wr_full), 0);

    // Read prefetch timing table.
    do_reset();
    fill_mem();
    bmem[3] = 16'h1234;
    bmem[4] = 16'h5678;
    ack_en = 1;
    tv[0] = '{1, 25'h3, 0, 1, 16'h0, 0, 25'h0};
    tv[1] = '{0, 25'h0, 0, 1, 16'h0, 0, 25'h0};
    tv[2] = '{0, 25'h0, 0, 1, 16'h0, 1, 25'h3};
    tv[3] = '{0, 25'h0, 0, 0, 16'h1234, 0, 25'h0};
    tv[4] = '{0, 25'h0, 0, 0, 16'h1234, 1, 25'h4};
    tv[5] = '{0, 25'h0, 1, 0, 16'h1234, 0, 25'h0};
    tv[6] = '{0, 25'h0, 0, 0, 16'h5678, 1, 25'h5};
    tv[7] = '{0, 25'h0, 1, 0, 16'h5678, 0, 25'h0};
    tv[8] = '{0, 25'h0, 0, 0, pat(5), 1, 25'h6};
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("tv%0d_empty", k), 32'(rd_empty),
          32'(tv[k].e_empty));
      if (!tv[k].e_empty)
        chk($sformatf("tv%0d_data", k), 32'(readdata),
            32'(tv[k].e_data));
      chk($sformatf("tv%0d_req", k), 32'(mem_req),
          32'(tv[k].e_req));
      if (tv[k].e_req) begin
        chk($sformatf("tv%0d_addr", k), 32'(mem_addr),
            32'(tv[k].e_addr));
        chk($sformatf("tv%0d_we", k), 32'(mem_we), 0);
      end
      read_ld = tv[k].rld;
      readaddr = tv[k].raddr;
      read_req = tv[k].rreq;
      cyc();
    end
    idle_in();

    // Write/read arbitration alternates, write first.
    do_reset();
    fill_mem();
    log_q.delete();
    ack_en = 1;
    write_ld = 1; writeaddr = 25'h30;
    write_req = 1; writedata = 16'hC0;
    read_ld = 1; readaddr = 25'h50;
    cyc();
    write_ld = 0; read_ld = 0;
    for (int i = 1; i < 4; i++) begin
      writedata = 16'hC0 + 16'(i);
      cyc();
    end
    write_req = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("alt_n", 32'(log_q.size() >= 4), 1);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("alt_we%0d", i), 32'(log_q[i].we),
          32'((i % 2) == 0));
    if (log_q.size() >= 2) begin
      chk("alt_w0_addr", 32'(log_q[0].addr), 32'h30);
      chk("alt_r0_addr", 32'(log_q[1].addr), 32'h50);
    end

    // Reload during a pending read discards its data.
    do_reset();
    fill_mem();
    bmem[3] = 16'h1234;
    bmem[8'h20] = 16'hBEEF;
    ack_en = 0;
    read_ld = 1; readaddr = 25'h3;
    cyc();
    read_ld = 0;
    n = 0;
    while (!mem_req && n < 10) begin cyc(); n++; end
    chk("stale_wait_req", 32'(mem_req), 1);
    chk("stale_addr", 32'(mem_addr), 32'h3);
    read_ld = 1; readaddr = 25'h20;
    cyc();
    read_ld = 0;
    ack_en = 1;
    n = 0;
    while (rd_empty && n < 20) begin cyc(); n++; end
    chk("stale_wait_data", 32'(rd_empty), 0);
    chk("stale_data", 32'(readdata), 32'hBEEF);

    // Reset while a read is pending.
    ack_en = 0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 20) begin
      cyc(); n++;
    end
    chk("mid_rst_busy", 32'(mem_req), 1);
    reset = 1;
    cyc();
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_empty", 32'(rd_empty), 1);
    chk("mid_rst_full", 32'(wr_full), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    reset = 0;
    cyc();

    // Randomized traffic against a queue model.
    do_reset();
    fill_mem();
    wq.delete();
    mw = 0; mr = 0; npush = 0; npop = 0; nread = 0;
    write_ld = 1; writeaddr = 25'h40;
    read_ld = 1; readaddr = 25'h80;
    ack_en = 0;
    cyc();
    idle_in();
    for (int c = 0; c < 300; c++) begin
      chk("rnd_full", 32'(wr_full), 32'(mw == 8));
      chk("rnd_empty", 32'(rd_empty), 32'(mr == 0));
      write_req = (npush < 60) && ($urandom_range(0, 1) == 1);
      wd = 16'($urandom);
      writedata = wd;
      read_req = ($urandom_range(0, 2) == 0);
      ack_en = ($urandom_range(0, 1) == 1);
      if (write_req && mw < 8) begin
        wq.push_back('{25'h40 + 25'(npush), wd});
        npush++;
        mw++;
      end
      if (read_req && mr > 0) begin
        chk("rnd_pop", 32'(readdata), 32'(pat(8'h80 + npop)));
        npop++;
        mr--;
      end
      if (mem_req && ack_en) begin
        if (mem_we) begin
          if (wq.size() > 0) begin
            chk("rnd_waddr", 32'(mem_addr), 32'(wq[0].addr));
            chk("rnd_wdata", 32'(mem_wdata), 32'(wq[0].data));
            void'(wq.pop_front());
          end else begin
            chk("rnd_wspur", 32'(mem_we), 0);
          end
          mw--;
        end else begin
          chk("rnd_raddr", 32'(mem_addr), 32'h80 + nread);
          nread++;
          mr++;
        end
      end
      cyc();
    end
    idle_in();
    chk("rnd_progress", 32'(npop > 0 && npush > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
